// File: rtl/key_entry_conditioner_if.sv
// Bus between the push-button/switch front end and its consumer.
// The master drives the raw board inputs; the slave (the conditioner) returns strobes.
interface key_entry_conditioner_if;
  logic [3:0] buttons_raw;
  logic [3:0] switches_raw;
  logic [3:0] enable;
  logic [3:0] entered_password;
  logic       press_error;
  logic       busy;

  modport master (
    output buttons_raw,
    output switches_raw,
    input  enable,
    input  entered_password,
    input  press_error,
    input  busy
  );

  modport slave (
    input  buttons_raw,
    input  switches_raw,
    output enable,
    output entered_password,
    output press_error,
    output busy
  );
endinterface

// File: rtl/key_entry_conditioner.sv
// Synchronise, debounce and arbitrate four push-buttons into one-cycle press strobes.
// Define KEY_ACTIVE_LOW_EN for active-low board keys (switches stay active-high).
module key_entry_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input logic                    clk,
  input logic                    rst,
  key_entry_conditioner_if.slave bus
);

`ifdef KEY_ACTIVE_LOW_EN
  localparam logic [3:0] BTN_RELEASED = 4'b1111;
`else
  localparam logic [3:0] BTN_RELEASED = 4'b0000;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT_REL} state_t;

  logic [7:0]       sync1_q;
  logic [7:0]       sync2_q;
  logic [7:0]       level;
  logic [7:0]       db_q;
  logic [CNT_W-1:0] cnt_q [8];
  logic [3:0]       db_btn;
  logic             one_pressed;
  state_t           state_q;
  logic [3:0]       enable_q;
  logic             press_error_q;
  logic             busy_q;

  // Bits [3:0] are buttons, [7:4] switches; flops reset to the released raw level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= {4'b0000, BTN_RELEASED};
      sync2_q <= {4'b0000, BTN_RELEASED};
    end else begin
      sync1_q <= {bus.switches_raw, bus.buttons_raw};
      sync2_q <= sync1_q;
    end
  end

  assign level = {sync2_q[7:4], sync2_q[3:0] ^ BTN_RELEASED};

  // Counter clears on agreement, so any glitch back to the old level restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q <= '0;
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (level[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_q[i] <= '0;
          db_q[i]  <= ~db_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign db_btn      = db_q[3:0];
  assign one_pressed = ($countones(db_btn) == 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      enable_q      <= '0;
      press_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      enable_q      <= '0;
      press_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (one_pressed) begin
            state_q  <= STROBE;
            enable_q <= db_btn;
          end else if (db_btn != 4'b0000) begin
            state_q       <= WAIT_REL;
            press_error_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        STROBE: begin
          state_q <= WAIT_REL;
          busy_q  <= 1'b1;
        end
        WAIT_REL: begin
          if (db_btn == 4'b0000) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.enable           = enable_q;
  assign bus.press_error      = press_error_q;
  assign bus.busy             = busy_q;
  assign bus.entered_password = db_q[7:4];

endmodule
